audio_level_meter: RTL and testbench

Read-side consumer of the stereo audio FIFO. It pops 32-bit stereo words written by the audio capture stage, computes the per-channel absolute peak over a fixed window of samples, and applies a peak-hold with exponential decay. It publishes left/right level values and clip flags once per window to the visualizer display logic. It runs entirely in the system clock domain; the FIFO's read port is the clock-domain boundary.

---
 rtl/audio_level_meter.sv | 152 +++++++++++++++
 tb/tb_audio_level_meter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_level_meter.sv
// Stereo FIFO consumer: per-window absolute peak per channel, peak-hold with
// exponential decay, and clip flags published once per window.
module audio_level_meter #(
  parameter int unsigned WINDOW_SAMPLES = 1024,
  parameter int unsigned DECAY_SHIFT    = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        rdempty_sig,
  input  logic [31:0] q_sig,
  output logic        rdreq_sig,
  output logic [14:0] left_level,
  output logic [14:0] right_level,
  output logic        left_clip,
  output logic        right_clip,
  output logic        level_valid
);

  localparam int unsigned SMP_W = 16;
  localparam int unsigned MAG_W = 15;
  localparam int unsigned CNT_W = $clog2(WINDOW_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_SAMPLES - 1);
  localparam logic [MAG_W-1:0] MAG_MAX  = {MAG_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    PUBLISH = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             rdreq_q, rdreq_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAG_W-1:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
  logic             wclip_l_q, wclip_l_d, wclip_r_q, wclip_r_d;
  logic [MAG_W-1:0] held_l_q, held_l_d, held_r_q, held_r_d;
  logic             oclip_l_q, oclip_l_d, oclip_r_q, oclip_r_d;
  logic [MAG_W-1:0] mag_l, mag_r;

  // |x| with -32768 saturating to the largest positive magnitude
  function automatic logic [MAG_W-1:0] abs_sat(input logic [SMP_W-1:0] x);
    logic [SMP_W-1:0] n;
    n = x[SMP_W-1] ? (~x + SMP_W'(1)) : x;
    return (x == {1'b1, {(SMP_W-1){1'b0}}}) ? MAG_MAX : n[MAG_W-1:0];
  endfunction

  // Decay the held level by at least 1 while non-zero, then take the max with the window peak
  function automatic logic [MAG_W-1:0] hold_next(input logic [MAG_W-1:0] held,
                                                  input logic [MAG_W-1:0] peak);
    logic [MAG_W-1:0] dec;
    logic [MAG_W-1:0] rem;
    dec = held >> DECAY_SHIFT;
    if ((dec == '0) && (held != '0)) dec = MAG_W'(1);
    rem = held - dec;
    return (peak > rem) ? peak : rem;
  endfunction

  assign mag_l = abs_sat(q_sig[31:16]);
  assign mag_r = abs_sat(q_sig[15:0]);

  always_comb begin
    state_d   = state_q;
    rdreq_d   = 1'b0;
    valid_d   = 1'b0;
    cnt_d     = cnt_q;
    peak_l_d  = peak_l_q;
    peak_r_d  = peak_r_q;
    wclip_l_d = wclip_l_q;
    wclip_r_d = wclip_r_q;
    held_l_d  = held_l_q;
    held_r_d  = held_r_q;
    oclip_l_d = oclip_l_q;
    oclip_r_d = oclip_r_q;
    case (state_q)
      IDLE: begin
        if (!rdempty_sig) begin
          state_d = READ;
          rdreq_d = 1'b1;
        end
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        if (mag_l > peak_l_q) peak_l_d = mag_l;
        if (mag_r > peak_r_q) peak_r_d = mag_r;
        if (mag_l == MAG_MAX) wclip_l_d = 1'b1;
        if (mag_r == MAG_MAX) wclip_r_d = 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = PUBLISH;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      PUBLISH: begin
        held_l_d  = hold_next(held_l_q, peak_l_q);
        held_r_d  = hold_next(held_r_q, peak_r_q);
        oclip_l_d = wclip_l_q;
        oclip_r_d = wclip_r_q;
        valid_d   = 1'b1;
        peak_l_d  = '0;
        peak_r_d  = '0;
        wclip_l_d = 1'b0;
        wclip_r_d = 1'b0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      rdreq_q   <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      peak_l_q  <= '0;
      peak_r_q  <= '0;
      wclip_l_q <= 1'b0;
      wclip_r_q <= 1'b0;
      held_l_q  <= '0;
      held_r_q  <= '0;
      oclip_l_q <= 1'b0;
      oclip_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdreq_q   <= rdreq_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      peak_l_q  <= peak_l_d;
      peak_r_q  <= peak_r_d;
      wclip_l_q <= wclip_l_d;
      wclip_r_q <= wclip_r_d;
      held_l_q  <= held_l_d;
      held_r_q  <= held_r_d;
      oclip_l_q <= oclip_l_d;
      oclip_r_q <= oclip_r_d;
    end
  end

  // The held level is what the display shows
  assign rdreq_sig   = rdreq_q;
  assign level_valid = valid_q;
  assign left_level  = held_l_q;
  assign right_level = held_r_q;
  assign left_clip   = oclip_l_q;
  assign right_clip  = oclip_r_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed and randomized-FIFO bench for audio_level_meter (WINDOW_SAMPLES=4, DECAY_SHIFT=2).
module tb_audio_level_meter;

  localparam int unsigned WIN = 4;
  localparam int unsigned DSH = 2;

  typedef struct packed {
    logic [14:0] ll;
    logic [14:0] rl;
    logic        lc;
    logic        rc;
  } pub_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rdempty_sig = 1'b1;
  logic [31:0] q_sig = '0;
  logic        rdreq_sig;
  logic [14:0] left_level, right_level;
  logic        left_clip, right_clip, level_valid;

  audio_level_meter #(.WINDOW_SAMPLES(WIN), .DECAY_SHIFT(DSH)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .rdempty_sig(rdempty_sig),
    .q_sig      (q_sig),
    .rdreq_sig  (rdreq_sig),
    .left_level (left_level),
    .right_level(right_level),
    .left_clip  (left_clip),
    .right_clip (right_clip),
    .level_valid(level_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // FIFO model: normal mode, data appears the cycle after rdreq
  logic [31:0] fifo_q[$];
  pub_t        exp_q[$];
  logic        force_empty = 1'b1;
  logic        rand_en = 1'b0;
  int          cyc = 0;
  int          pop_empty = 0;

  always @(posedge clk) begin
    cyc++;
    if (rdreq_sig) begin
      if (fifo_q.size() > 0) q_sig <= fifo_q.pop_front();
      else begin
        pop_empty++;
        q_sig <= '0;
      end
    end
    rdempty_sig <= force_empty || (fifo_q.size() == 0) || (rand_en && ($urandom_range(0, 3) == 0));
  end

  // Output monitor
  int   rdreq_cnt = 0, lv_cnt = 0;
  int   empty_viol = 0, consec_viol = 0, stable_viol = 0;
  int   rdreq_t[$], lv_t[$];
  logic prev_empty = 1'b1, prev_rdreq = 1'b0, prev_reset = 1'b1;
  logic [31:0] last_out = '0;
  pub_t e;

  always @(negedge clk) begin
    if (!reset && !prev_reset) begin
      if (rdreq_sig) begin
        rdreq_cnt++;
        rdreq_t.push_back(cyc);
        if (prev_empty) empty_viol++;
        if (prev_rdreq) consec_viol++;
      end
      if (level_valid) begin
        lv_cnt++;
        lv_t.push_back(cyc);
        if (exp_q.size() == 0) check_eq("unexpected_level_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("left_level", left_level, e.ll);
          check_eq("right_level", right_level, e.rl);
          check_eq("left_clip", left_clip, e.lc);
          check_eq("right_clip", right_clip, e.rc);
        end
        last_out = {left_level, right_level, left_clip, right_clip};
      end else if ({left_level, right_level, left_clip, right_clip} !== last_out[31:0]) begin
        stable_viol++;
      end
    end else begin
      last_out = {left_level, right_level, left_clip, right_clip};
    end
    prev_empty = rdempty_sig;
    prev_rdreq = rdreq_sig;
    prev_reset = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic clear_stats();
    rdreq_cnt = 0;
    lv_cnt    = 0;
    rdreq_t.delete();
    lv_t.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || (fifo_q.size() != 0)) && (n < budget)) begin
      tick();
      n++;
    end
    check_eq({tag, "_timeout"}, (n >= budget), 0);
    repeat (20) tick();
  endtask

  function automatic pub_t mk(input int ll, input int rl, input bit lc, input bit rc);
    pub_t p;
    p.ll = 15'(ll);
    p.rl = 15'(rl);
    p.lc = lc;
    p.rc = rc;
    return p;
  endfunction

  // Reference model for the random test
  int m_pk_l, m_pk_r, m_held_l, m_held_r, m_cnt;
  bit m_cl_l, m_cl_r;

  function automatic int ref_mag(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic int ref_hold(input int held, input int pk);
    int d, nh;
    d = held / (1 << DSH);
    if (d == 0 && held > 0) d = 1;
    nh = held - d;
    return (pk > nh) ? pk : nh;
  endfunction

  task automatic model_push(input logic [31:0] w);
    int ml, mr;
    ml = ref_mag(w[31:16]);
    mr = ref_mag(w[15:0]);
    if (ml > m_pk_l) m_pk_l = ml;
    if (mr > m_pk_r) m_pk_r = mr;
    if (ml == 32767) m_cl_l = 1;
    if (mr == 32767) m_cl_r = 1;
    m_cnt++;
    if (m_cnt == WIN) begin
      m_held_l = ref_hold(m_held_l, m_pk_l);
      m_held_r = ref_hold(m_held_r, m_pk_r);
      exp_q.push_back(mk(m_held_l, m_held_r, m_cl_l, m_cl_r));
      m_pk_l = 0; m_pk_r = 0; m_cl_l = 0; m_cl_r = 0; m_cnt = 0;
    end
  endtask

  function automatic logic [15:0] rnd_sample();
    logic signed [15:0] v;
    case ($urandom_range(0, 15))
      0:       v = 16'sh8000;
      1:       v = 16'sh7FFF;
      2:       v = 16'sh8001;
      default: v = 16'($urandom) >>> $urandom_range(0, 14);
    endcase
    return v;
  endfunction

  int decay_tbl[27] = '{1000, 750, 563, 423, 318, 239, 180, 135, 102, 77, 58, 44, 33, 25,
                        19, 15, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0, 0};

  initial begin
    logic [31:0] w;
    int n;

    // Reset state and idle behaviour with an empty FIFO
    force_empty = 1'b1;
    pulse_reset();
    check_eq("rst_rdreq", rdreq_sig, 0);
    check_eq("rst_valid", level_valid, 0);
    check_eq("rst_left_level", left_level, 0);
    check_eq("rst_right_level", right_level, 0);
    check_eq("rst_left_clip", left_clip, 0);
    check_eq("rst_right_clip", right_clip, 0);
    clear_stats();
    repeat (100) tick();
    check_eq("idle_rdreq_cnt", rdreq_cnt, 0);
    check_eq("idle_lv_cnt", lv_cnt, 0);
    check_eq("idle_levels", {left_level, right_level, left_clip, right_clip}, 0);

    // One window with saturating -32768 on the right
    force_empty = 1'b0;
    exp_q.push_back(mk(256, 32767, 0, 1));
    fifo_q.push_back(32'h0100_0001);
    fifo_q.push_back(32'hFF00_8000);
    fifo_q.push_back(32'h0050_7FFE);
    fifo_q.push_back(32'h0000_0000);
    drain("basic", 200);
    check_eq("basic_lv_cnt", lv_cnt, 1);

    // Decay with DECAY_SHIFT=2 down to zero, under a permanently non-empty FIFO
    pulse_reset();
    clear_stats();
    foreach (decay_tbl[i]) exp_q.push_back(mk(decay_tbl[i], 0, 0, 0));
    fifo_q.push_back(32'h03E8_0000);
    for (int i = 0; i < 27 * WIN - 1; i++) fifo_q.push_back(32'h0);
    drain("decay", 1000);
    check_eq("decay_lv_cnt", lv_cnt, 27);
    if (lv_t.size() >= 2 && rdreq_t.size() >= 2) begin
      check_eq("lv_period", lv_t[1] - lv_t[0], 13);
      check_eq("rdreq_period", rdreq_t[1] - rdreq_t[0], 3);
    end else begin
      check_eq("period_samples", 0, 1);
    end

    // Reset mid-window discards the partial window
    pulse_reset();
    fifo_q.push_back(32'h4E20_B1E0);
    fifo_q.push_back(32'h4E20_B1E0);
    n = 0;
    while (fifo_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("midreset_pop_timeout", (n >= 100), 0);
    tick();
    pulse_reset();
    clear_stats();
    exp_q.push_back(mk(100, 100, 0, 0));
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'h0064_FF9C);
    drain("midreset", 200);
    check_eq("midreset_lv_cnt", lv_cnt, 1);

    // Random FIFO availability, model-checked peaks and holds
    pulse_reset();
    clear_stats();
    m_pk_l = 0; m_pk_r = 0; m_held_l = 0; m_held_r = 0; m_cnt = 0; m_cl_l = 0; m_cl_r = 0;
    rand_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      w = {rnd_sample(), rnd_sample()};
      fifo_q.push_back(w);
      model_push(w);
    end
    drain("random", 80000);
    rand_en = 1'b0;
    check_eq("random_rdreq_cnt", rdreq_cnt, 10000);
    check_eq("random_lv_cnt", lv_cnt, 2500);
    check_eq("rdreq_while_empty", empty_viol, 0);
    check_eq("rdreq_consecutive", consec_viol, 0);
    check_eq("pop_of_empty_fifo", pop_empty, 0);
    check_eq("outputs_unstable", stable_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
